myproject_div_26s_10ns_16_seq: RTL and testbench



---
 rtl/myproject_div_pkg.sv | 13 +
 rtl/myproject_div_sat.sv | 58 +++++
 rtl/myproject_div_26s_10ns_16_seq.sv | 115 +++++++++++
 tb/tb_myproject_div_26s_10ns_16_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/myproject_div_pkg.sv
// Shared types and constants for the sequential signed/unsigned divider.
package myproject_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam int DIN0_W = 26;
  localparam int DIN1_W = 10;
  localparam int DOUT_W = 16;
  localparam int CNT_W  = $clog2(DIN0_W);
  localparam int QMAX   = 2**(DOUT_W-1) - 1;
  localparam int QMIN   = -(2**(DOUT_W-1));

endpackage

// File: rtl/myproject_div_sat.sv
// Final-cycle result shaping: sign restore, saturation, ovf/dz flags.
// Rounding (half away from zero) is compiled in only with MYPROJECT_DIV_ROUND_EN.
module myproject_div_sat
  import myproject_div_pkg::*;
#(
  parameter int QW = DIN0_W,
  parameter int RW = DIN1_W,
  parameter int OW = DOUT_W
) (
  input  logic                 neg,
  input  logic [QW-1:0]        qmag,
  input  logic [RW:0]          rmag,
  input  logic [RW-1:0]        dvs,
  output logic signed [OW-1:0] dout,
  output logic signed [RW:0]   rem,
  output logic                 ovf,
  output logic                 dz
);

  localparam logic [QW:0] POS_LIM = (QW+1)'(QMAX);
  localparam logic [QW:0] NEG_LIM = (QW+1)'(-QMIN);

  logic [QW:0]   qr;
  logic [OW-1:0] qlo;

`ifdef MYPROJECT_DIV_ROUND_EN
  logic up;
  // 2*|rem| >= divisor rounds the magnitude up; rem output stays truncated
  assign up = ({rmag, 1'b0} >= {2'b00, dvs});
  assign qr = {1'b0, qmag} + (QW+1)'(up);
`else
  assign qr = {1'b0, qmag};
`endif

  assign qlo = qr[OW-1:0];
  assign dz  = (dvs == '0);

  always_comb begin
    dout = '0;
    rem  = '0;
    ovf  = 1'b0;
    if (dz) begin
      dout = neg ? OW'(QMIN) : OW'(QMAX);
    end else begin
      rem = neg ? signed'(~rmag + 1'b1) : signed'(rmag);
      if (!neg && qr > POS_LIM) begin
        dout = OW'(QMAX);
        ovf  = 1'b1;
      end else if (neg && qr > NEG_LIM) begin
        dout = OW'(QMIN);
        ovf  = 1'b1;
      end else begin
        dout = neg ? signed'(~qlo + 1'b1) : signed'(qlo);
      end
    end
  end

endmodule

// File: rtl/myproject_div_26s_10ns_16_seq.sv
// Radix-2 restoring divider: signed 26b dividend / unsigned 10b divisor -> saturated signed 16b quotient.
// Optional rounding via MYPROJECT_DIV_ROUND_EN (see myproject_div_sat).
module myproject_div_26s_10ns_16_seq
  import myproject_div_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         start,
  output logic                         ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0]        din1,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic signed [din1_WIDTH:0]   rem,
  output logic                         dout_vld,
  output logic                         ovf,
  output logic                         dz
);

  localparam int rem_WIDTH = din1_WIDTH + 1;
  localparam int CW        = $clog2(din0_WIDTH);

  state_t                 state, nstate;
  logic [CW-1:0]          cnt;
  logic                   neg;
  logic [din0_WIDTH-1:0]  dvd;   // dividend magnitude; quotient bits shift in at the LSB
  logic [din1_WIDTH-1:0]  dvs;
  logic [din1_WIDTH:0]    prem;  // partial remainder, always < dvs between steps
  logic [din1_WIDTH:0]    sh, diff;
  logic                   qbit;

  logic signed [dout_WIDTH-1:0] s_dout;
  logic signed [rem_WIDTH-1:0]  s_rem;
  logic                         s_ovf, s_dz;

  assign ready = (state == IDLE);

  assign sh   = {prem[din1_WIDTH-1:0], dvd[din0_WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  assign qbit = (sh >= {1'b0, dvs});

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (start) nstate = (din1 == '0) ? FIN : CALC;
      CALC: if (cnt == '0) nstate = FIN;
      FIN:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)   state <= IDLE;
    else if (ce) state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      neg      <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      prem     <= '0;
      dout     <= '0;
      rem      <= '0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
      dout_vld <= 1'b0;
    end else if (ce) begin
      dout_vld <= 1'b0;
      case (state)
        IDLE: if (start) begin
          neg  <= din0[din0_WIDTH-1];
          dvd  <= din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
          dvs  <= din1;
          prem <= '0;
          cnt  <= CW'(din0_WIDTH-1);
        end
        CALC: begin
          prem <= qbit ? diff : sh;
          dvd  <= {dvd[din0_WIDTH-2:0], qbit};
          cnt  <= cnt - 1'b1;
        end
        FIN: begin
          dout     <= s_dout;
          rem      <= s_rem;
          ovf      <= s_ovf;
          dz       <= s_dz;
          dout_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  myproject_div_sat #(
    .QW(din0_WIDTH),
    .RW(din1_WIDTH),
    .OW(dout_WIDTH)
  ) u_sat (
    .neg  (neg),
    .qmag (dvd),
    .rmag (prem),
    .dvs  (dvs),
    .dout (s_dout),
    .rem  (s_rem),
    .ovf  (s_ovf),
    .dz   (s_dz)
  );

endmodule

// File: tb/tb_myproject_div_26s_10ns_16_seq.sv
// Directed self-checking bench for myproject_div_26s_10ns_16_seq.
module tb_myproject_div_26s_10ns_16_seq;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ce = 1'b1;
  logic               start = 1'b0;
  logic               ready;
  logic signed [25:0] din0 = '0;
  logic [9:0]         din1 = '0;
  logic signed [15:0] dout;
  logic signed [10:0] rem;
  logic               dout_vld, ovf, dz;

  int errors = 0;
  int checks = 0;

`ifdef MYPROJECT_DIV_ROUND_EN
  localparam int Q1000_7 = 143;
`else
  localparam int Q1000_7 = 142;
`endif

  myproject_div_26s_10ns_16_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .ready(ready),
    .din0(din0), .din1(din1), .dout(dout), .rem(rem),
    .dout_vld(dout_vld), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where dout_vld is seen.
  // edges = posedges after the accept edge.
  task automatic run_op(input logic signed [25:0] a, input logic [9:0] b, output int edges);
    din0 = a; din1 = b; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (!dout_vld && edges < 100) begin
      @(posedge clk); @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1 || dout_vld !== 1'b0 || dout !== 16'sd0 || rem !== 11'sd0 || ovf !== 1'b0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b vld=%b dout=%0d rem=%0d ovf=%b dz=%b required 1 0 0 0 0 0",
               ready, dout_vld, dout, rem, ovf, dz);
    end
  endtask

  task automatic test_basic();
    int e;
    run_op(26'sd1000, 10'd7, e);
    checks++;
    if (e !== 27) begin errors++; $display("FAIL basic_latency: got %0d required 27", e); end
    checks++;
    if (int'(dout) !== Q1000_7 || int'(rem) !== 6 || ovf !== 1'b0 || dz !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_1000_7: dout=%0d rem=%0d ovf=%b dz=%b ready=%b required %0d 6 0 0 1",
               dout, rem, ovf, dz, ready, Q1000_7);
    end
    ce = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (dout_vld !== 1'b1) begin errors++; $display("FAIL vld_hold_stall: got %b required 1", dout_vld); end
    ce = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (dout_vld !== 1'b0 || int'(dout) !== Q1000_7) begin
      errors++; $display("FAIL vld_clear: vld=%b dout=%0d required 0 %0d", dout_vld, dout, Q1000_7);
    end
  endtask

  task automatic test_negative();
    int e;
    run_op(-26'sd1000, 10'd7, e);
    checks++;
    if (int'(dout) !== -Q1000_7 || int'(rem) !== -6 || ovf !== 1'b0) begin
      errors++; $display("FAIL neg_1000_7: dout=%0d rem=%0d ovf=%b required %0d -6 0", dout, rem, ovf, -Q1000_7);
    end
    @(posedge clk); @(negedge clk);
    run_op(-26'sd33554432, 10'd1, e);
    checks++;
    if (int'(dout) !== -32768 || int'(rem) !== 0 || ovf !== 1'b1 || dz !== 1'b0) begin
      errors++; $display("FAIL neg_min_sat: dout=%0d rem=%0d ovf=%b dz=%b required -32768 0 1 0", dout, rem, ovf, dz);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_saturation();
    int e;
    run_op(26'sd33554431, 10'd1, e);
    checks++;
    if (int'(dout) !== 32767 || int'(rem) !== 0 || ovf !== 1'b1) begin
      errors++; $display("FAIL pos_sat: dout=%0d rem=%0d ovf=%b required 32767 0 1", dout, rem, ovf);
    end
    @(posedge clk); @(negedge clk);
    run_op(26'sd65534, 10'd2, e);
    checks++;
    if (int'(dout) !== 32767 || int'(rem) !== 0 || ovf !== 1'b0) begin
      errors++; $display("FAIL pos_edge: dout=%0d rem=%0d ovf=%b required 32767 0 0", dout, rem, ovf);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_div_zero();
    int e;
    run_op(26'sd500, 10'd0, e);
    checks++;
    if (e !== 1) begin errors++; $display("FAIL dz_latency: got %0d edges after accept required 1", e); end
    checks++;
    if (int'(dout) !== 32767 || int'(rem) !== 0 || dz !== 1'b1 || ovf !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL dz_pos: dout=%0d rem=%0d dz=%b ovf=%b ready=%b required 32767 0 1 0 1",
                         dout, rem, dz, ovf, ready);
    end
    @(posedge clk); @(negedge clk);
    run_op(-26'sd500, 10'd0, e);
    checks++;
    if (int'(dout) !== -32768 || int'(rem) !== 0 || dz !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL dz_neg: dout=%0d rem=%0d dz=%b ovf=%b required -32768 0 1 0", dout, rem, dz, ovf);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_stall();
    int e;
    din0 = 26'sd1000; din1 = 10'd7; start = 1'b1;
    @(posedge clk); @(negedge clk);
    e = 0;
    din0 = 26'sd5; din1 = 10'd1;
    repeat (3) begin @(posedge clk); @(negedge clk); e++; end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b required 0", ready); end
    start = 1'b0; ce = 1'b0;
    repeat (5) begin @(posedge clk); @(negedge clk); e++; end
    ce = 1'b1;
    while (!dout_vld && e < 100) begin @(posedge clk); @(negedge clk); e++; end
    checks++;
    if (e !== 32) begin errors++; $display("FAIL stall_latency: got %0d required 32", e); end
    checks++;
    if (int'(dout) !== Q1000_7 || int'(rem) !== 6) begin
      errors++; $display("FAIL stall_result: dout=%0d rem=%0d required %0d 6", dout, rem, Q1000_7);
    end
    repeat (2) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (ready !== 1'b1 || dout_vld !== 1'b0) begin
      errors++; $display("FAIL no_queue: ready=%b vld=%b required 1 0", ready, dout_vld);
    end
  endtask

  task automatic test_reset_abort();
    int e;
    din0 = 26'sd1000; din1 = 10'd7; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (15) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1 || dout_vld !== 1'b0 || dout !== 16'sd0 || rem !== 11'sd0 || ovf !== 1'b0 || dz !== 1'b0) begin
      errors++; $display("FAIL reset_abort: ready=%b vld=%b dout=%0d rem=%0d ovf=%b dz=%b required 1 0 0 0 0 0",
                         ready, dout_vld, dout, rem, ovf, dz);
    end
    run_op(26'sd1000, 10'd7, e);
    checks++;
    if (e !== 27 || int'(dout) !== Q1000_7 || int'(rem) !== 6) begin
      errors++; $display("FAIL after_abort: edges=%0d dout=%0d rem=%0d required 27 %0d 6", e, dout, rem, Q1000_7);
    end
  endtask

  // Entered at the negedge of a dout_vld cycle: next op is accepted while vld is high
  task automatic test_back_to_back();
    int e;
    run_op(-26'sd1000, 10'd7, e);
    checks++;
    if (e !== 27 || int'(dout) !== -Q1000_7 || int'(rem) !== -6) begin
      errors++; $display("FAIL b2b_first: edges=%0d dout=%0d rem=%0d required 27 %0d -6", e, dout, rem, -Q1000_7);
    end
    run_op(26'sd700, 10'd10, e);
    checks++;
    if (e !== 27 || int'(dout) !== 70 || int'(rem) !== 0 || ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_second: edges=%0d dout=%0d rem=%0d ovf=%b required 27 70 0 0", e, dout, rem, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_div_zero();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
